// File: rtl/mdio_arbiter.sv
// mdio_arbiter: shares one MDIO management master between two requesters
// (host register port = requester 0, PHY link poller = requester 1).
// Round-robin grant, builds the Clause-22 frame on T_DATA, pulses MDIO_START,
// waits for DATA_RDY (read) or the falling edge of MDIO_OE (write), then
// returns RDATA plus a one-cycle ACK to the granted requester.
//
// Ports:
//   clk, rst (async active-low)
//   REQn / REQn_WR / REQn_PHY / REQn_REG / REQn_WDATA : requester n (n = 0, 1)
//   RD_DATA, DATA_RDY, MDIO_OE : status from the MDIO master
//   MDIO_START, T_DATA        : launch pulse and frame to the MDIO master
//   ACK0, ACK1, RDATA, ERR    : completion back to the requesters
//   BUSY                      : high whenever the arbiter is not idle
//
// Build option: define MDIO_ARB_TIMEOUT_EN to abort a transaction that has
// not completed TIMEOUT_CYC cycles after launch (ACK with ERR=1, RDATA=0).
// Without it ERR is constant 0 and BUSY waits indefinitely.
module mdio_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned TW          = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic        REQ0_WR,
  input  logic        REQ1_WR,
  input  logic [4:0]  REQ0_PHY,
  input  logic [4:0]  REQ1_PHY,
  input  logic [4:0]  REQ0_REG,
  input  logic [4:0]  REQ1_REG,
  input  logic [15:0] REQ0_WDATA,
  input  logic [15:0] REQ1_WDATA,
  input  logic [15:0] RD_DATA,
  input  logic        DATA_RDY,
  input  logic        MDIO_OE,
  output logic        MDIO_START,
  output logic [31:0] T_DATA,
  output logic        ACK0,
  output logic        ACK1,
  output logic [15:0] RDATA,
  output logic        ERR,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_BUSY   = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Elaboration-time guard: the timeout counter must be able to hold TIMEOUT_CYC.
  if ((64'(1) << TW) <= 64'(TIMEOUT_CYC)) begin : g_tw_check
    $error("mdio_arbiter: 2**TW must exceed TIMEOUT_CYC");
  end

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;        // round-robin pointer: requester favoured on a tie
  logic        gnt_q, gnt_d;        // requester owning the current transaction
  logic        wr_q, wr_d;          // current transaction is a write
  logic        seen_oe_q, seen_oe_d;
  logic        oe_q;                // MDIO_OE delayed one cycle for edge detect
  logic [31:0] t_data_q, t_data_d;
  logic        start_q, start_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [15:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;
`ifdef MDIO_ARB_TIMEOUT_EN
  logic [TW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  logic        sel;
  logic        sel_wr;
  logic [4:0]  sel_phy;
  logic [4:0]  sel_reg;
  logic [15:0] sel_wdata;
  logic        done_rd;
  logic        done_wr;

  // Grant selection: a lone request wins outright, a tie goes to the pointer.
  always_comb begin
    sel       = (REQ0 && REQ1) ? ptr_q : REQ1;
    sel_wr    = sel ? REQ1_WR    : REQ0_WR;
    sel_phy   = sel ? REQ1_PHY   : REQ0_PHY;
    sel_reg   = sel ? REQ1_REG   : REQ0_REG;
    sel_wdata = sel ? REQ1_WDATA : REQ0_WDATA;
    done_rd   = !wr_q && DATA_RDY;
    // A fall only counts once OE has been seen high during this transaction.
    done_wr   = wr_q && oe_q && !MDIO_OE && seen_oe_q;
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    wr_d      = wr_q;
    seen_oe_d = seen_oe_q;
    t_data_d  = t_data_q;
    start_d   = 1'b0;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rdata_d   = rdata_q;
`ifdef MDIO_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (REQ0 || REQ1) begin
          gnt_d    = sel;
          wr_d     = sel_wr;
          t_data_d = {2'b01, (sel_wr ? 2'b01 : 2'b10), sel_phy, sel_reg,
                      (sel_wr ? 2'b10 : 2'b00), (sel_wr ? sel_wdata : 16'h0000)};
          start_d  = 1'b1;
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        seen_oe_d = 1'b0;
`ifdef MDIO_ARB_TIMEOUT_EN
        cnt_d     = '0;
`endif
        state_d   = S_BUSY;
      end
      S_BUSY: begin
        seen_oe_d = seen_oe_q | MDIO_OE;
        if (done_rd || done_wr) begin
          if (!wr_q) rdata_d = RD_DATA;
`ifdef MDIO_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          ack0_d  = !gnt_q;
          ack1_d  = gnt_q;
          state_d = S_DONE;
        end
`ifdef MDIO_ARB_TIMEOUT_EN
        else if (cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          rdata_d = 16'h0000;
          err_d   = 1'b1;
          ack0_d  = !gnt_q;
          ack1_d  = gnt_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
`endif
      end
      S_DONE: begin
        ptr_d   = ~gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= 1'b0;
      gnt_q     <= 1'b0;
      wr_q      <= 1'b0;
      seen_oe_q <= 1'b0;
      oe_q      <= 1'b0;
      t_data_q  <= 32'h0;
      start_q   <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rdata_q   <= 16'h0;
      busy_q    <= 1'b0;
`ifdef MDIO_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      wr_q      <= wr_d;
      seen_oe_q <= seen_oe_d;
      oe_q      <= MDIO_OE;
      t_data_q  <= t_data_d;
      start_q   <= start_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
`ifdef MDIO_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign MDIO_START = start_q;
  assign T_DATA     = t_data_q;
  assign ACK0       = ack0_q;
  assign ACK1       = ack1_q;
  assign RDATA      = rdata_q;
  assign BUSY       = busy_q;
`ifdef MDIO_ARB_TIMEOUT_EN
  assign ERR        = err_q;
`else
  assign ERR        = 1'b0;
`endif

endmodule

// File: tb/tb_mdio_arbiter.sv
// Self-checking bench for mdio_arbiter: directed write/read, spurious events,
// round-robin contention, optional timeout and mid-transaction reset.
module tb_mdio_arbiter;

  logic        clk;
  logic        rst;
  logic        REQ0, REQ1, REQ0_WR, REQ1_WR;
  logic [4:0]  REQ0_PHY, REQ1_PHY, REQ0_REG, REQ1_REG;
  logic [15:0] REQ0_WDATA, REQ1_WDATA, RD_DATA;
  logic        DATA_RDY, MDIO_OE;
  logic        MDIO_START, ACK0, ACK1, ERR, BUSY;
  logic [31:0] T_DATA;
  logic [15:0] RDATA;

  typedef struct {
    int          who;
    bit          wr;
    logic [31:0] frame;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          overlap = 0;
  logic [15:0] mdl_rdata = 16'h0;

  mdio_arbiter #(.TIMEOUT_CYC(64), .TW(11)) dut (
    .clk(clk), .rst(rst),
    .REQ0(REQ0), .REQ1(REQ1), .REQ0_WR(REQ0_WR), .REQ1_WR(REQ1_WR),
    .REQ0_PHY(REQ0_PHY), .REQ1_PHY(REQ1_PHY), .REQ0_REG(REQ0_REG), .REQ1_REG(REQ1_REG),
    .REQ0_WDATA(REQ0_WDATA), .REQ1_WDATA(REQ1_WDATA),
    .RD_DATA(RD_DATA), .DATA_RDY(DATA_RDY), .MDIO_OE(MDIO_OE),
    .MDIO_START(MDIO_START), .T_DATA(T_DATA), .ACK0(ACK0), .ACK1(ACK1),
    .RDATA(RDATA), .ERR(ERR), .BUSY(BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_frame(bit wr, logic [4:0] phy, logic [4:0] rg, logic [15:0] wd);
    return {2'b01, (wr ? 2'b01 : 2'b10), phy, rg, (wr ? 2'b10 : 2'b00), (wr ? wd : 16'h0)};
  endfunction

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (MDIO_START === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_ack(input int bound, output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (ACK0 === 1'b1 && ACK1 === 1'b1) overlap++;
      if (ACK0 === 1'b1 || ACK1 === 1'b1) begin ok = 1'b1; cyc = i; break; end
    end
  endtask

  // Plays the MDIO master for one transaction, entered on the launch cycle.
  task automatic respond(input bit wr, input logic [15:0] rd, input int len);
    repeat (2) @(negedge clk);
    if (wr) begin
      MDIO_OE = 1'b1;
      repeat (len) @(negedge clk);
      MDIO_OE = 1'b0;
    end else begin
      RD_DATA  = rd;
      DATA_RDY = 1'b1;
      @(posedge clk);
      #1;
      DATA_RDY = 1'b0;
      RD_DATA  = 16'h0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    REQ0 = 0; REQ1 = 0; REQ0_WR = 0; REQ1_WR = 0;
    REQ0_PHY = 0; REQ1_PHY = 0; REQ0_REG = 0; REQ1_REG = 0;
    REQ0_WDATA = 0; REQ1_WDATA = 0; RD_DATA = 0; DATA_RDY = 0; MDIO_OE = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    mdl_rdata = 16'h0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    REQ0 = 0; REQ1 = 0; REQ0_WR = 0; REQ1_WR = 0;
    REQ0_PHY = 0; REQ1_PHY = 0; REQ0_REG = 0; REQ1_REG = 0;
    REQ0_WDATA = 0; REQ1_WDATA = 0; RD_DATA = 0; DATA_RDY = 0; MDIO_OE = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({MDIO_START, ACK0, ACK1, ERR, BUSY} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000", {MDIO_START, ACK0, ACK1, ERR, BUSY});
    end
    total++;
    if (T_DATA !== 32'h0 || RDATA !== 16'h0) begin
      bad++; $display("FAIL reset_data: got T_DATA=%h RDATA=%h want 0/0", T_DATA, RDATA);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (BUSY !== 1'b0 || MDIO_START !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset: got BUSY=%b START=%b want 0/0", BUSY, MDIO_START);
    end
  endtask

  task automatic test_write0();
    exp_t e;
    bit ok;
    int cyc, spur;
    e.who = 0; e.wr = 1; e.frame = 32'h5A5AFFFF; e.rdata = mdl_rdata; e.err = 1'b0;
    sb.push_back(e);
    REQ0_WR = 1; REQ0_PHY = 5'h14; REQ0_REG = 5'h16; REQ0_WDATA = 16'hFFFF; REQ0 = 1;
    wait_start(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL w0_start: got no MDIO_START want pulse"); end
    total++;
    if (T_DATA !== sb[0].frame) begin bad++; $display("FAIL w0_frame: got %h want %h", T_DATA, sb[0].frame); end
    @(negedge clk);
    total++;
    if (MDIO_START !== 1'b0 || BUSY !== 1'b1) begin
      bad++; $display("FAIL w0_pulse: got START=%b BUSY=%b want 0/1", MDIO_START, BUSY);
    end
    spur = 0;
    MDIO_OE = 1'b1;
    repeat (64) begin
      @(negedge clk);
      if (ACK0 === 1'b1 || ACK1 === 1'b1) spur++;
    end
    MDIO_OE = 1'b0;
    total++;
    if (spur != 0) begin bad++; $display("FAIL w0_early_ack: got %0d acks want 0", spur); end
    wait_ack(10, ok, cyc);
    total++;
    if (!ok || cyc != 1) begin bad++; $display("FAIL w0_ack_latency: got ok=%0d cyc=%0d want 1/1", ok, cyc); end
    e = sb.pop_front();
    total++;
    if (ACK0 !== 1'b1 || ACK1 !== 1'b0 || ERR !== e.err || RDATA !== e.rdata) begin
      bad++; $display("FAIL w0_result: got ACK0=%b ACK1=%b ERR=%b RDATA=%h want 1/0/%b/%h",
                      ACK0, ACK1, ERR, RDATA, e.err, e.rdata);
    end
    REQ0 = 0;
    @(negedge clk);
    total++;
    if (ACK0 !== 1'b0) begin bad++; $display("FAIL w0_ack_pulse: got ACK0=%b want 0", ACK0); end
  endtask

  task automatic test_read1();
    exp_t e;
    bit ok;
    int cyc;
    e.who = 1; e.wr = 0; e.frame = 32'h60880000; e.rdata = 16'hBEEF; e.err = 1'b0;
    sb.push_back(e);
    REQ1_WR = 0; REQ1_PHY = 5'h01; REQ1_REG = 5'h02; REQ1_WDATA = 16'h0; REQ1 = 1;
    wait_start(ok);
    total++;
    if (!ok || T_DATA !== sb[0].frame) begin
      bad++; $display("FAIL r1_frame: got ok=%0d T_DATA=%h want %h", ok, T_DATA, sb[0].frame);
    end
    respond(1'b0, sb[0].rdata, 0);
    wait_ack(10, ok, cyc);
    e = sb.pop_front();
    mdl_rdata = e.rdata;
    total++;
    if (!ok || ACK1 !== 1'b1 || ACK0 !== 1'b0 || RDATA !== e.rdata || ERR !== e.err) begin
      bad++; $display("FAIL r1_result: got ok=%0d ACK0=%b ACK1=%b RDATA=%h ERR=%b want 1/0/1/%h/%b",
                      ok, ACK0, ACK1, RDATA, ERR, e.rdata, e.err);
    end
    REQ1 = 0;
    repeat (3) @(negedge clk);
    total++;
    if (ACK1 !== 1'b0 || RDATA !== mdl_rdata) begin
      bad++; $display("FAIL r1_hold: got ACK1=%b RDATA=%h want 0/%h", ACK1, RDATA, mdl_rdata);
    end
  endtask

  task automatic test_spurious();
    exp_t e;
    bit ok;
    int cyc, spur;
    RD_DATA = 16'h5555; DATA_RDY = 1'b1;
    @(negedge clk);
    DATA_RDY = 1'b0; RD_DATA = 16'h0;
    spur = 0;
    repeat (4) begin
      @(negedge clk);
      if (ACK0 === 1'b1 || ACK1 === 1'b1 || BUSY === 1'b1) spur++;
    end
    total++;
    if (spur != 0 || RDATA !== mdl_rdata) begin
      bad++; $display("FAIL idle_data_rdy: got events=%0d RDATA=%h want 0/%h", spur, RDATA, mdl_rdata);
    end
    // OE already high before launch; its fall in the first busy cycle must be ignored.
    MDIO_OE = 1'b1;
    e.who = 0; e.wr = 1; e.frame = mk_frame(1'b1, 5'h02, 5'h03, 16'hA5A5); e.rdata = mdl_rdata; e.err = 1'b0;
    sb.push_back(e);
    REQ0_WR = 1; REQ0_PHY = 5'h02; REQ0_REG = 5'h03; REQ0_WDATA = 16'hA5A5; REQ0 = 1;
    wait_start(ok);
    total++;
    if (!ok || T_DATA !== sb[0].frame) begin
      bad++; $display("FAIL sp_frame: got ok=%0d T_DATA=%h want %h", ok, T_DATA, sb[0].frame);
    end
    @(negedge clk);
    MDIO_OE = 1'b0;
    spur = 0;
    repeat (5) begin
      @(negedge clk);
      if (ACK0 === 1'b1 || ACK1 === 1'b1) spur++;
    end
    total++;
    if (spur != 0 || BUSY !== 1'b1) begin
      bad++; $display("FAIL early_oe_fall: got acks=%0d BUSY=%b want 0/1", spur, BUSY);
    end
    MDIO_OE = 1'b1;
    repeat (8) @(negedge clk);
    MDIO_OE = 1'b0;
    wait_ack(10, ok, cyc);
    e = sb.pop_front();
    total++;
    if (!ok || cyc != 1 || ACK0 !== 1'b1 || ERR !== e.err || RDATA !== e.rdata) begin
      bad++; $display("FAIL real_oe_fall: got ok=%0d cyc=%0d ACK0=%b ERR=%b RDATA=%h want 1/1/1/%b/%h",
                      ok, cyc, ACK0, ERR, RDATA, e.err, e.rdata);
    end
    REQ0 = 0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    exp_t e;
    bit ok;
    int cyc, w;
    int issued[2];
    do_reset();
    overlap = 0;
    issued[0] = 1; issued[1] = 1;
    REQ0_WR = 0; REQ0_PHY = 5'h03; REQ0_REG = 5'h04;
    REQ1_WR = 1; REQ1_PHY = 5'h05; REQ1_REG = 5'h06; REQ1_WDATA = 16'h1230;
    e.who = 0; e.wr = 0; e.frame = mk_frame(1'b0, 5'h03, 5'h04, 16'h0); e.rdata = 16'hA000; e.err = 1'b0;
    sb.push_back(e);
    e.who = 1; e.wr = 1; e.frame = mk_frame(1'b1, 5'h05, 5'h06, 16'h1230); e.rdata = 16'h0; e.err = 1'b0;
    sb.push_back(e);
    REQ0 = 1; REQ1 = 1;
    for (int t = 0; t < 6; t++) begin
      wait_start(ok);
      total++;
      if (!ok || sb.size() == 0 || T_DATA !== sb[0].frame) begin
        bad++; $display("FAIL cont_frame[%0d]: got ok=%0d T_DATA=%h want %h", t, ok, T_DATA,
                        (sb.size() != 0) ? sb[0].frame : 32'h0);
      end
      if (sb.size() == 0) break;
      respond(sb[0].wr, sb[0].rdata, 6);
      wait_ack(20, ok, cyc);
      e = sb.pop_front();
      if (!e.wr) mdl_rdata = e.rdata;
      w = (ACK1 === 1'b1) ? 1 : 0;
      total++;
      if (!ok || w != e.who || RDATA !== mdl_rdata || ERR !== 1'b0) begin
        bad++; $display("FAIL cont_grant[%0d]: got ok=%0d who=%0d RDATA=%h ERR=%b want %0d/%h/0",
                        t, ok, w, RDATA, ERR, e.who, mdl_rdata);
      end
      if (w == 0) REQ0 = 0; else REQ1 = 0;
      @(negedge clk);
      if (issued[w] < 3) begin
        if (w == 0) begin
          REQ0_REG = 5'(4 + issued[0]);
          e.who = 0; e.wr = 0; e.frame = mk_frame(1'b0, 5'h03, REQ0_REG, 16'h0);
          e.rdata = 16'hA000 + 16'(issued[0]); e.err = 1'b0;
          REQ0 = 1;
        end else begin
          REQ1_WDATA = 16'h1230 + 16'(issued[1]);
          e.who = 1; e.wr = 1; e.frame = mk_frame(1'b1, 5'h05, 5'h06, REQ1_WDATA);
          e.rdata = 16'h0; e.err = 1'b0;
          REQ1 = 1;
        end
        sb.push_back(e);
        issued[w]++;
      end
    end
    total++;
    if (overlap != 0) begin bad++; $display("FAIL ack_overlap: got %0d want 0", overlap); end
  endtask

`ifdef MDIO_ARB_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    bit ok;
    int cyc;
    e.who = 0; e.wr = 0; e.frame = mk_frame(1'b0, 5'h07, 5'h08, 16'h0); e.rdata = 16'h0; e.err = 1'b1;
    sb.push_back(e);
    REQ0_WR = 0; REQ0_PHY = 5'h07; REQ0_REG = 5'h08; REQ0 = 1;
    wait_start(ok);
    wait_ack(200, ok, cyc);
    e = sb.pop_front();
    mdl_rdata = e.rdata;
    total++;
    if (!ok || cyc < 60 || cyc > 70 || ACK0 !== 1'b1 || ERR !== e.err || RDATA !== e.rdata) begin
      bad++; $display("FAIL timeout: got ok=%0d cyc=%0d ACK0=%b ERR=%b RDATA=%h want 1/60..70/1/1/0000",
                      ok, cyc, ACK0, ERR, RDATA);
    end
    REQ0 = 0;
    @(negedge clk);
    e.who = 0; e.wr = 0; e.frame = mk_frame(1'b0, 5'h07, 5'h09, 16'h0); e.rdata = 16'h1357; e.err = 1'b0;
    sb.push_back(e);
    REQ0_REG = 5'h09; REQ0 = 1;
    wait_start(ok);
    respond(1'b0, sb[0].rdata, 0);
    wait_ack(10, ok, cyc);
    e = sb.pop_front();
    mdl_rdata = e.rdata;
    total++;
    if (!ok || ACK0 !== 1'b1 || ERR !== 1'b0 || RDATA !== e.rdata) begin
      bad++; $display("FAIL after_timeout: got ok=%0d ACK0=%b ERR=%b RDATA=%h want 1/1/0/%h",
                      ok, ACK0, ERR, RDATA, e.rdata);
    end
    REQ0 = 0;
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid();
    exp_t e;
    bit ok;
    int cyc, w;
    REQ0_WR = 1; REQ0_PHY = 5'h01; REQ0_REG = 5'h01; REQ0_WDATA = 16'h0001; REQ0 = 1;
    wait_start(ok);
    @(negedge clk);
    MDIO_OE = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({MDIO_START, ACK0, ACK1, ERR, BUSY} !== 5'b0 || T_DATA !== 32'h0 || RDATA !== 16'h0) begin
      bad++; $display("FAIL reset_mid: got ctrl=%b T_DATA=%h RDATA=%h want 0/0/0",
                      {MDIO_START, ACK0, ACK1, ERR, BUSY}, T_DATA, RDATA);
    end
    REQ0 = 0; MDIO_OE = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mdl_rdata = 16'h0;
    @(negedge clk);
    e.who = 0; e.wr = 0; e.frame = mk_frame(1'b0, 5'h04, 5'h04, 16'h0); e.rdata = 16'h0A0A; e.err = 1'b0;
    sb.push_back(e);
    e.who = 1; e.wr = 0; e.frame = mk_frame(1'b0, 5'h06, 5'h06, 16'h0); e.rdata = 16'h0B0B; e.err = 1'b0;
    sb.push_back(e);
    REQ0_WR = 0; REQ0_PHY = 5'h04; REQ0_REG = 5'h04;
    REQ1_WR = 0; REQ1_PHY = 5'h06; REQ1_REG = 5'h06;
    REQ0 = 1; REQ1 = 1;
    for (int t = 0; t < 2; t++) begin
      wait_start(ok);
      total++;
      if (!ok || T_DATA !== sb[0].frame) begin
        bad++; $display("FAIL rst_frame[%0d]: got ok=%0d T_DATA=%h want %h", t, ok, T_DATA, sb[0].frame);
      end
      respond(1'b0, sb[0].rdata, 0);
      wait_ack(10, ok, cyc);
      e = sb.pop_front();
      w = (ACK1 === 1'b1) ? 1 : 0;
      total++;
      if (!ok || w != e.who || RDATA !== e.rdata) begin
        bad++; $display("FAIL rst_grant[%0d]: got ok=%0d who=%0d RDATA=%h want %0d/%h",
                        t, ok, w, RDATA, e.who, e.rdata);
      end
      if (w == 0) REQ0 = 0; else REQ1 = 0;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_write0();
    test_read1();
    test_spurious();
    test_contention();
`ifdef MDIO_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
